// File: rtl/mvm_pkg.sv
// -----------------------------------------------------------------------------
// mvm_pkg
// Shared definitions for the MVM issue logic.
//   state_t       : issue sequencer state (IDLE waits for a command, RUN issues)
//   ISSUE_LATENCY : cycles from an issue decision to o_valid at the datapath
// -----------------------------------------------------------------------------
package mvm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int ISSUE_LATENCY = 1;

endpackage : mvm_pkg

// File: rtl/datapath_issue_cnt.sv
// -----------------------------------------------------------------------------
// datapath_issue_cnt
// Nested chunk/row counter for the issue sequencer. The row counter is the
// inner loop and the chunk counter the outer loop. Limits are captured on load.
//   clk, rst    : clock, asynchronous active-high reset
//   load        : capture rows/chunks limits and clear both counters
//   step        : advance one (chunk, row) position
//   rows/chunks : loop limits (only meaningful when both are non-zero)
//   row/chunk   : current position
//   row_last    : row is the final row of the current chunk
//   chunk_last  : chunk is the final chunk
//   done        : current position is the final (chunk, row) pair
// -----------------------------------------------------------------------------
module datapath_issue_cnt #(
    parameter int ROWW = 10,
    parameter int CNTW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [ROWW-1:0] rows,
    input  logic [CNTW-1:0] chunks,
    output logic [ROWW-1:0] row,
    output logic [CNTW-1:0] chunk,
    output logic            row_last,
    output logic            chunk_last,
    output logic            done
);

    logic [ROWW-1:0] rows_r;
    logic [CNTW-1:0] chunks_r;
    logic [ROWW-1:0] row_r;
    logic [CNTW-1:0] chunk_r;

    // Limit capture and nested counting; row wraps into the next chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_r   <= {ROWW{1'b0}};
            chunks_r <= {CNTW{1'b0}};
            row_r    <= {ROWW{1'b0}};
            chunk_r  <= {CNTW{1'b0}};
        end else if (load) begin
            rows_r   <= rows;
            chunks_r <= chunks;
            row_r    <= {ROWW{1'b0}};
            chunk_r  <= {CNTW{1'b0}};
        end else if (step) begin
            if (row_last) begin
                row_r <= {ROWW{1'b0}};
                if (chunk_last) begin
                    chunk_r <= {CNTW{1'b0}};
                end else begin
                    chunk_r <= chunk_r + CNTW'(1);
                end
            end else begin
                row_r <= row_r + ROWW'(1);
            end
        end
    end

    assign row        = row_r;
    assign chunk      = chunk_r;
    assign row_last   = (row_r == rows_r - ROWW'(1));
    assign chunk_last = (chunk_r == chunks_r - CNTW'(1));
    assign done       = row_last && chunk_last;

endmodule : datapath_issue_cnt

// File: rtl/datapath_issue.sv
// -----------------------------------------------------------------------------
// datapath_issue
// Issue sequencer for one MVM datapath lane. Walks a tile command chunk by
// chunk (outer) and row by row (inner), popping one input-vector chunk at the
// start of every chunk and one reduce operand per row of the last chunk when
// reduction is requested, while streaming weight words from the weight RAM.
//   clk, rst                  : clock, asynchronous active-high reset
//   i_cmd_* / o_cmd_ready     : tile command (rows, chunks, bases, reduce)
//   i_vec_* / o_vec_ready     : input-vector chunk stream
//   i_red_* / o_red_ready     : reduce operand stream
//   o_wmem_raddr/i_wmem_rdata : weight RAM port, one-cycle read latency
//   o_valid..o_reduce         : datapath operands and controls
//   o_busy                    : command in progress or final issue in flight
//   o_done                    : one-cycle completion pulse
// -----------------------------------------------------------------------------
module datapath_issue
    import mvm_pkg::*;
#(
    parameter int DATAW     = 512,
    parameter int IPREC     = 8,
    parameter int MEM_DEPTH = 512,
    parameter int ADDRW     = $clog2(MEM_DEPTH),
    parameter int WADDRW    = 10,
    parameter int CNTW      = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDRW:0]    i_cmd_rows,
    input  logic [CNTW-1:0]   i_cmd_chunks,
    input  logic [ADDRW-1:0]  i_cmd_accum_base,
    input  logic [WADDRW-1:0] i_cmd_waddr_base,
    input  logic              i_cmd_reduce,
    input  logic              i_vec_valid,
    output logic              o_vec_ready,
    input  logic [DATAW-1:0]  i_vec_data,
    input  logic              i_red_valid,
    output logic              o_red_ready,
    input  logic [IPREC-1:0]  i_red_data,
    output logic [WADDRW-1:0] o_wmem_raddr,
    input  logic [DATAW-1:0]  i_wmem_rdata,
    output logic              o_valid,
    output logic [DATAW-1:0]  o_dataa,
    output logic [DATAW-1:0]  o_datab,
    output logic [IPREC-1:0]  o_datac,
    output logic [ADDRW-1:0]  o_accum_addr,
    output logic              o_accum,
    output logic              o_last,
    output logic              o_reduce,
    output logic              o_busy,
    output logic              o_done
);

    localparam int ROWW = ADDRW + 1;

    state_t            state_r;
    logic [ADDRW-1:0]  accum_base_r;
    logic              reduce_r;
    logic [WADDRW-1:0] w_r;
    logic [DATAW-1:0]  hold_r;

    logic [ROWW-1:0]   row_s;
    logic [CNTW-1:0]   chunk_s;
    logic              row_last_s;
    logic              chunk_last_s;
    logic              cnt_done_s;

    logic              run_s;
    logic              cmd_fire_s;
    logic              zero_cmd_s;
    logic              need_vec_s;
    logic              need_red_s;
    logic              vec_ok_s;
    logic              red_ok_s;
    logic              fire_s;
    logic [ADDRW+1:0]  addr_sum_s;
    logic [ADDRW-1:0]  addr_s;

    assign run_s      = (state_r == RUN);
    assign cmd_fire_s = (state_r == IDLE) && i_cmd_valid;
    assign zero_cmd_s = (i_cmd_rows == ROWW'(0)) || (i_cmd_chunks == CNTW'(0));

    // A fresh vector chunk is needed at row 0; reduce operands only on the last chunk.
    assign need_vec_s = (row_s == ROWW'(0));
    assign need_red_s = reduce_r && chunk_last_s;
    assign vec_ok_s   = !need_vec_s || i_vec_valid;
    assign red_ok_s   = !need_red_s || i_red_valid;
    assign fire_s     = run_s && vec_ok_s && red_ok_s;

    // Each stream only pops when the other operand is also present, so a
    // pop always coincides with an issue and nothing is consumed on a bubble.
    assign o_vec_ready = run_s && need_vec_s && red_ok_s;
    assign o_red_ready = run_s && need_red_s && vec_ok_s;

    assign o_cmd_ready  = (state_r == IDLE);
    assign o_wmem_raddr = w_r;
    assign o_datab      = i_wmem_rdata;
    assign o_busy       = run_s || o_valid;

    datapath_issue_cnt #(
        .ROWW (ROWW),
        .CNTW (CNTW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (cmd_fire_s),
        .step       (fire_s),
        .rows       (i_cmd_rows),
        .chunks     (i_cmd_chunks),
        .row        (row_s),
        .chunk      (chunk_s),
        .row_last   (row_last_s),
        .chunk_last (chunk_last_s),
        .done       (cnt_done_s)
    );

    // Accumulator address with modular wrap; the sum stays below 2*MEM_DEPTH.
    always_comb begin
        addr_sum_s = {2'b00, accum_base_r} + {1'b0, row_s};
        if (addr_sum_s >= (ADDRW+2)'(MEM_DEPTH)) begin
            addr_s = ADDRW'(addr_sum_s - (ADDRW+2)'(MEM_DEPTH));
        end else begin
            addr_s = addr_sum_s[ADDRW-1:0];
        end
    end

    // Vector hold register: reused by rows 1..R-1 of the current chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_r <= {DATAW{1'b0}};
        end else if (fire_s && need_vec_s) begin
            hold_r <= i_vec_data;
        end
    end

    // Sequencer FSM with registered datapath outputs and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            accum_base_r <= {ADDRW{1'b0}};
            reduce_r     <= 1'b0;
            w_r          <= {WADDRW{1'b0}};
            o_valid      <= 1'b0;
            o_dataa      <= {DATAW{1'b0}};
            o_datac      <= {IPREC{1'b0}};
            o_accum_addr <= {ADDRW{1'b0}};
            o_accum      <= 1'b0;
            o_last       <= 1'b0;
            o_reduce     <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_valid <= fire_s;
            o_done  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_fire_s) begin
                        accum_base_r <= i_cmd_accum_base;
                        reduce_r     <= i_cmd_reduce;
                        w_r          <= i_cmd_waddr_base;
                        if (zero_cmd_s) begin
                            // Empty tile: nothing to issue, complete right away.
                            o_done  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            state_r <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fire_s) begin
                        o_dataa      <= need_vec_s ? i_vec_data : hold_r;
                        o_datac      <= need_red_s ? i_red_data : IPREC'(0);
                        o_accum_addr <= addr_s;
                        o_accum      <= (chunk_s != CNTW'(0));
                        o_last       <= chunk_last_s;
                        o_reduce     <= need_red_s;
                        w_r          <= w_r + WADDRW'(1);
                        if (cnt_done_s) begin
                            // Pulse lines up with the final o_valid.
                            o_done  <= 1'b1;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule : datapath_issue
